// File: rtl/reflet_mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding and requester index constants.
package reflet_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/reflet_mem_arbiter_pick.sv
// Combinational winner selection between two requesters, either
// round-robin on the last grant or with requester 0 winning ties.
module reflet_mem_arbiter_pick
  import reflet_mem_arbiter_pkg::*;
#(
  parameter bit fixed_priority = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  // Winner selection; with no request the last grant is reported unchanged.
  always_comb begin
    valid  = req0 | req1;
    winner = last_grant;
    if (req0 && req1) begin
      if (fixed_priority) begin
        winner = REQ_0;
      end else begin
        winner = ~last_grant;
      end
    end else if (req0) begin
      winner = REQ_0;
    end else if (req1) begin
      winner = REQ_1;
    end else begin
      winner = last_grant;
    end
  end

endmodule

// File: rtl/reflet_mem_arbiter.sv
// Shares one downstream memory port between two requesters, running one
// transaction at a time through an IDLE/ISSUE/WAIT/DONE sequence.
module reflet_mem_arbiter
  import reflet_mem_arbiter_pkg::*;
#(
  parameter int wordsize       = 16,
  parameter bit fixed_priority = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] r0_addr,
  input  logic [wordsize-1:0] r1_addr,
  input  logic [wordsize-1:0] r0_data_out,
  input  logic [wordsize-1:0] r1_data_out,
  output logic [wordsize-1:0] r0_data_in,
  output logic [wordsize-1:0] r1_data_in,
  input  logic                r0_write_en,
  input  logic                r1_write_en,
  input  logic                r0_read_en,
  input  logic                r1_read_en,
  output logic                r0_ready,
  output logic                r1_ready,
  output logic [wordsize-1:0] sub_addr,
  output logic [wordsize-1:0] sub_data_out,
  input  logic [wordsize-1:0] sub_data_in,
  output logic                sub_write_en,
  output logic                sub_read_en,
  input  logic                sub_ready,
  output logic                grant,
  output logic                busy
);

  arb_state_t          state_r, state_s;
  logic                grant_r, grant_s;
  logic                write_kind_r, write_kind_s;
  logic [wordsize-1:0] sub_addr_r, sub_addr_s;
  logic [wordsize-1:0] sub_data_out_r, sub_data_out_s;
  logic                sub_write_en_r, sub_write_en_s;
  logic                sub_read_en_r, sub_read_en_s;
  logic                r0_ready_r, r0_ready_s;
  logic                r1_ready_r, r1_ready_s;
  logic [wordsize-1:0] r0_data_in_r, r0_data_in_s;
  logic [wordsize-1:0] r1_data_in_r, r1_data_in_s;
  logic                busy_r, busy_s;
  logic                pick_valid_s;
  logic                pick_winner_s;
  logic                win_write_s;

  reflet_mem_arbiter_pick #(
    .fixed_priority(fixed_priority)
  ) u_pick (
    .req0      (r0_write_en | r0_read_en),
    .req1      (r1_write_en | r1_read_en),
    .last_grant(grant_r),
    .valid     (pick_valid_s),
    .winner    (pick_winner_s)
  );

  // Write wins over read when a requester raises both enables.
  assign win_write_s = (pick_winner_s == REQ_1) ? r1_write_en : r0_write_en;

  // Next-state and next-output computation; strobes and readies default low.
  always_comb begin
    state_s        = state_r;
    grant_s        = grant_r;
    write_kind_s   = write_kind_r;
    sub_addr_s     = sub_addr_r;
    sub_data_out_s = sub_data_out_r;
    sub_write_en_s = 1'b0;
    sub_read_en_s  = 1'b0;
    r0_ready_s     = 1'b0;
    r1_ready_s     = 1'b0;
    r0_data_in_s   = r0_data_in_r;
    r1_data_in_s   = r1_data_in_r;
    busy_s         = busy_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          grant_s        = pick_winner_s;
          write_kind_s   = win_write_s;
          sub_addr_s     = (pick_winner_s == REQ_1) ? r1_addr : r0_addr;
          sub_data_out_s = (pick_winner_s == REQ_1) ? r1_data_out : r0_data_out;
          sub_write_en_s = win_write_s;
          sub_read_en_s  = ~win_write_s;
          busy_s         = 1'b1;
          state_s        = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (sub_ready) begin
          if (!write_kind_r) begin
            if (grant_r == REQ_1) begin
              r1_data_in_s = sub_data_in;
            end else begin
              r0_data_in_s = sub_data_in;
            end
          end else begin
            r0_data_in_s = r0_data_in_r;
          end
          r0_ready_s = (grant_r == REQ_0);
          r1_ready_s = (grant_r == REQ_1);
          state_s    = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; enable low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      grant_r        <= REQ_1;
      write_kind_r   <= 1'b0;
      sub_addr_r     <= {wordsize{1'b0}};
      sub_data_out_r <= {wordsize{1'b0}};
      sub_write_en_r <= 1'b0;
      sub_read_en_r  <= 1'b0;
      r0_ready_r     <= 1'b0;
      r1_ready_r     <= 1'b0;
      r0_data_in_r   <= {wordsize{1'b0}};
      r1_data_in_r   <= {wordsize{1'b0}};
      busy_r         <= 1'b0;
    end else if (enable) begin
      state_r        <= state_s;
      grant_r        <= grant_s;
      write_kind_r   <= write_kind_s;
      sub_addr_r     <= sub_addr_s;
      sub_data_out_r <= sub_data_out_s;
      sub_write_en_r <= sub_write_en_s;
      sub_read_en_r  <= sub_read_en_s;
      r0_ready_r     <= r0_ready_s;
      r1_ready_r     <= r1_ready_s;
      r0_data_in_r   <= r0_data_in_s;
      r1_data_in_r   <= r1_data_in_s;
      busy_r         <= busy_s;
    end
  end

  assign r0_data_in   = r0_data_in_r;
  assign r1_data_in   = r1_data_in_r;
  assign r0_ready     = r0_ready_r;
  assign r1_ready     = r1_ready_r;
  assign sub_addr     = sub_addr_r;
  assign sub_data_out = sub_data_out_r;
  assign sub_write_en = sub_write_en_r;
  assign sub_read_en  = sub_read_en_r;
  assign grant        = grant_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Directed bench for reflet_mem_arbiter: a round-robin instance and a
// fixed-priority instance share stimulus; outputs are sampled on negedges.
module tb_reflet_mem_arbiter;

  logic        clk, reset, enable;
  logic [15:0] r0_addr, r1_addr, r0_data_out, r1_data_out;
  logic        r0_write_en, r1_write_en, r0_read_en, r1_read_en;
  logic [15:0] sub_data_in;
  logic        sub_ready;

  logic [15:0] r0_data_in, r1_data_in, sub_addr, sub_data_out;
  logic        r0_ready, r1_ready, sub_write_en, sub_read_en, grant, busy;
  logic [15:0] r0_data_in_f, r1_data_in_f, sub_addr_f, sub_data_out_f;
  logic        r0_ready_f, r1_ready_f, sub_write_en_f, sub_read_en_f, grant_f, busy_f;

  int n_assert = 0;
  int n_fail   = 0;
  logic g;

  reflet_mem_arbiter #(.wordsize(16), .fixed_priority(1'b0)) dut_rr (
    .clk(clk), .reset(reset), .enable(enable),
    .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_data_out(r0_data_out), .r1_data_out(r1_data_out),
    .r0_data_in(r0_data_in), .r1_data_in(r1_data_in),
    .r0_write_en(r0_write_en), .r1_write_en(r1_write_en),
    .r0_read_en(r0_read_en), .r1_read_en(r1_read_en),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .sub_addr(sub_addr), .sub_data_out(sub_data_out), .sub_data_in(sub_data_in),
    .sub_write_en(sub_write_en), .sub_read_en(sub_read_en), .sub_ready(sub_ready),
    .grant(grant), .busy(busy)
  );

  reflet_mem_arbiter #(.wordsize(16), .fixed_priority(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .enable(enable),
    .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_data_out(r0_data_out), .r1_data_out(r1_data_out),
    .r0_data_in(r0_data_in_f), .r1_data_in(r1_data_in_f),
    .r0_write_en(r0_write_en), .r1_write_en(r1_write_en),
    .r0_read_en(r0_read_en), .r1_read_en(r1_read_en),
    .r0_ready(r0_ready_f), .r1_ready(r1_ready_f),
    .sub_addr(sub_addr_f), .sub_data_out(sub_data_out_f), .sub_data_in(sub_data_in),
    .sub_write_en(sub_write_en_f), .sub_read_en(sub_read_en_f), .sub_ready(sub_ready),
    .grant(grant_f), .busy(busy_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1;
    r0_addr = 16'h0000; r1_addr = 16'h0000;
    r0_data_out = 16'h0000; r1_data_out = 16'h0000;
    r0_write_en = 1'b0; r1_write_en = 1'b0; r0_read_en = 1'b0; r1_read_en = 1'b0;
    sub_data_in = 16'h0000; sub_ready = 1'b1;
    step(); step();
    check1("rst_busy", busy, 1'b0);
    check1("rst_grant", grant, 1'b1);
    check1("rst_rd_strobe", sub_read_en, 1'b0);
    check1("rst_wr_strobe", sub_write_en, 1'b0);
    check1("rst_r0_ready", r0_ready, 1'b0);
    check16("rst_sub_addr", sub_addr, 16'h0000);
    check16("rst_r0_data", r0_data_in, 16'h0000);
    reset = 1'b1;

    // Test 1: single read, pass-through downstream
    r0_read_en = 1'b1; r0_addr = 16'h0040; sub_data_in = 16'hBEEF;
    step();
    check1("t1_issue_rd", sub_read_en, 1'b1);
    check1("t1_issue_wr", sub_write_en, 1'b0);
    check16("t1_issue_addr", sub_addr, 16'h0040);
    check1("t1_grant", grant, 1'b0);
    check1("t1_busy", busy, 1'b1);
    step();
    check1("t1_wait_rd", sub_read_en, 1'b0);
    check1("t1_wait_ready", r0_ready, 1'b0);
    step();
    check1("t1_done_r0_ready", r0_ready, 1'b1);
    check1("t1_done_r1_ready", r1_ready, 1'b0);
    check16("t1_done_data", r0_data_in, 16'hBEEF);
    r0_read_en = 1'b0;
    step();
    check1("t1_idle_ready", r0_ready, 1'b0);
    check1("t1_idle_busy", busy, 1'b0);

    // Test 2: round-robin with both requesters held
    do_reset();
    r0_addr = 16'h0100; r1_addr = 16'h0200;
    r0_read_en = 1'b1; r1_read_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      g = (k == 1);
      sub_data_in = 16'hA000 + 16'(k);
      step();
      check1("t2_grant", grant, g);
      check1("t2_busy_issue", busy, 1'b1);
      check1("t2_rd_strobe", sub_read_en, 1'b1);
      check16("t2_addr", sub_addr, g ? 16'h0200 : 16'h0100);
      step();
      check1("t2_busy_wait", busy, 1'b1);
      step();
      check1("t2_r0_ready", r0_ready, ~g);
      check1("t2_r1_ready", r1_ready, g);
      check16("t2_data", g ? r1_data_in : r0_data_in, 16'hA000 + 16'(k));
      check1("t2_busy_done", busy, 1'b1);
      if (k == 2) begin
        r0_read_en = 1'b0; r1_read_en = 1'b0;
      end
      step();
      check1("t2_busy_idle", busy, 1'b0);
    end

    // Test 4: write+read together on r1, write wins
    r1_write_en = 1'b1; r1_read_en = 1'b1;
    r1_addr = 16'h0002; r1_data_out = 16'h1234; sub_data_in = 16'hDEAD;
    step();
    check1("t4_wr_strobe", sub_write_en, 1'b1);
    check1("t4_rd_strobe", sub_read_en, 1'b0);
    check16("t4_wdata", sub_data_out, 16'h1234);
    check16("t4_addr", sub_addr, 16'h0002);
    check1("t4_grant", grant, 1'b1);
    step();
    step();
    check1("t4_r1_ready", r1_ready, 1'b1);
    check16("t4_r1_data_kept", r1_data_in, 16'hA001);
    r1_write_en = 1'b0; r1_read_en = 1'b0;
    step();
    check1("t4_idle_busy", busy, 1'b0);

    // Test 5: buffered downstream, ready three cycles after issue
    r0_read_en = 1'b1; r0_addr = 16'h0300; sub_ready = 1'b0;
    step();
    check1("t5_issue_rd", sub_read_en, 1'b1);
    check16("t5_addr", sub_addr, 16'h0300);
    for (int i = 0; i < 3; i++) begin
      step();
      check1("t5_wait_rd", sub_read_en, 1'b0);
      check1("t5_wait_wr", sub_write_en, 1'b0);
      check1("t5_wait_ready", r0_ready, 1'b0);
      check1("t5_wait_busy", busy, 1'b1);
      check16("t5_wait_addr", sub_addr, 16'h0300);
    end
    sub_ready = 1'b1; sub_data_in = 16'h5A5A;
    step();
    check1("t5_done_ready", r0_ready, 1'b1);
    check16("t5_done_data", r0_data_in, 16'h5A5A);
    r0_read_en = 1'b0;
    step();
    check1("t5_idle_busy", busy, 1'b0);

    // Test 3: fixed priority with both requesters held
    do_reset();
    r0_addr = 16'h0100; r1_addr = 16'h0200; sub_data_in = 16'hC0DE;
    r0_read_en = 1'b1; r1_read_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check1("t3_grant0", grant_f, 1'b0);
      check16("t3_addr0", sub_addr_f, 16'h0100);
      check1("t3_rd_strobe", sub_read_en_f, 1'b1);
      check1("t3_wr_strobe", sub_write_en_f, 1'b0);
      check16("t3_wdata", sub_data_out_f, 16'h0000);
      step();
      step();
      check1("t3_r0_ready", r0_ready_f, 1'b1);
      check1("t3_r1_ready", r1_ready_f, 1'b0);
      check16("t3_r0_data", r0_data_in_f, 16'hC0DE);
      if (k == 2) r0_read_en = 1'b0;
      step();
      check1("t3_idle_busy", busy_f, 1'b0);
    end
    sub_data_in = 16'hF00D;
    step();
    check1("t3_grant1", grant_f, 1'b1);
    check16("t3_addr1", sub_addr_f, 16'h0200);
    step();
    step();
    check1("t3_r1_ready_last", r1_ready_f, 1'b1);
    check16("t3_r1_data", r1_data_in_f, 16'hF00D);
    r1_read_en = 1'b0;
    step();
    check1("t3_end_busy", busy_f, 1'b0);

    // Test 6: async reset in WAIT, then tie after reset, then enable freeze
    r0_read_en = 1'b1; r0_addr = 16'h0400; sub_ready = 1'b0;
    step();
    check1("t6_grant0", grant, 1'b0);
    step();
    check1("t6_wait_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check1("t6_async_busy", busy, 1'b0);
    check1("t6_async_grant", grant, 1'b1);
    check16("t6_async_addr", sub_addr, 16'h0000);
    check1("t6_async_rd", sub_read_en, 1'b0);
    check1("t6_async_ready", r0_ready, 1'b0);
    step();
    reset = 1'b1; r1_read_en = 1'b1; sub_ready = 1'b1; sub_data_in = 16'h7777;
    step();
    check1("t6_tie_grant", grant, 1'b0);
    step();
    step();
    check1("t6_ready", r0_ready, 1'b1);
    check16("t6_data", r0_data_in, 16'h7777);
    enable = 1'b0;
    step();
    step();
    check1("t6_freeze_ready", r0_ready, 1'b1);
    check1("t6_freeze_busy", busy, 1'b1);
    enable = 1'b1;
    r0_read_en = 1'b0; r1_read_en = 1'b0;
    step();
    check1("t6_unfreeze_ready", r0_ready, 1'b0);
    check1("t6_unfreeze_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reflet_mem_arbiter.md
Name: reflet_mem_arbiter

Overview:
- Shares one downstream memory port between two requesters, typically a CPU and a DMA/debug master.
- The downstream port connects to the CPU side of the mini memory interface, in either buffered or pass-through mode.
- Arbitrates with round-robin or fixed priority and sequences one transaction at a time with an ISSUE/WAIT/DONE FSM.
- Returns registered read data and a one-cycle ready pulse to the granted requester.

Parameters:
- wordsize, 16, width of addresses and data.
- fixed_priority, 0; 0 = round-robin, 1 = requester 0 always wins ties.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when low, FSM and all registers hold their values.
- r0_addr / r1_addr  in  wordsize  requester address.
- r0_data_out / r1_data_out  in  wordsize  requester write data.
- r0_data_in / r1_data_in  out  wordsize  registered read data.
- r0_write_en / r1_write_en  in  1  write request, held until ready.
- r0_read_en / r1_read_en  in  1  read request, held until ready.
- r0_ready / r1_ready  out  1  one-cycle completion pulse.
- sub_addr  out  wordsize  to mini interface cpu_addr.
- sub_data_out  out  wordsize  to mini interface cpu_data_out.
- sub_data_in  in  wordsize  from mini interface cpu_data_in.
- sub_write_en / sub_read_en  out  1  one-cycle issue strobes.
- sub_ready  in  1  completion from the mini interface.
- grant  out  1  index of the current or last granted requester.
- busy  out  1  high in ISSUE, WAIT and DONE.

Behaviour:
- Reset (asynchronous, reset=0):
  - State IDLE.
  - sub_write_en, sub_read_en, r0_ready, r1_ready and busy all 0.
  - sub_addr, sub_data_out, r*_data_in all 0.
  - last_grant=1, grant=1.
- All outputs are registered.
- Request for requester n = rn_write_en | rn_read_en. If both are high, write wins and no read is performed.
- IDLE:
  - No request: stay in IDLE.
  - One requester active: grant it.
  - Both active, fixed_priority=1: grant 0.
  - Both active, round-robin: grant !last_grant.
  - On grant: latch that requester's addr and data_out into sub_addr/sub_data_out, latch its write/read kind, set grant and last_grant, go to ISSUE.
- ISSUE (exactly one cycle):
  - Exactly one of sub_write_en / sub_read_en is high.
  - sub_addr and sub_data_out are stable.
  - Next state is WAIT.
  - sub_ready is ignored in this cycle.
- WAIT:
  - Strobes are 0; sub_addr and sub_data_out are held.
  - On a clock edge with sub_ready=1: for reads, capture sub_data_in into the granted r*_data_in (writes leave it unchanged); pulse the granted r*_ready; go to DONE.
  - There is no timeout.
- DONE (one cycle):
  - Granted ready=1, the other ready=0.
  - Next state is IDLE. The requester drops its enables in response.
  - Requests are not sampled in DONE.
- Latency with a pass-through downstream (sub_ready tied 1): request sampled at edge E0 → ISSUE in cycle 1, WAIT in cycle 2, ready pulse in cycle 3. Back-to-back throughput is one transaction per 4 cycles.
- Buffered downstream: WAIT lasts until the interface's ready pulse (3 cycles for reads, 2 for writes).
- The non-granted requester waits with its enables held. Its request is never lost, and round-robin guarantees service within one transaction.
- A requester dropping its enable mid-transaction does not abort the transaction: it completes downstream and the ready pulse is still produced.
- enable=0 freezes state and outputs. A ready pulse in progress is stretched until enable returns.
- Reset mid-transaction abandons the downstream access immediately. The mini interface is reset on the same net.
- r*_data_in keeps its last value between reads.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3;
  - requester index constants.
- One natural sub-module: reflet_mem_arbiter_pick. It is combinational and computes the winner from r0/r1 requests, last_grant and fixed_priority.

Test Plan:
1. Single read: r0_read_en=1, r0_addr=16'h0040, sub_ready tied 1, sub_data_in=16'hBEEF → sub_read_en high for one cycle with sub_addr=16'h0040; r0_ready pulses in cycle 3 with r0_data_in=16'hBEEF; r1_ready stays 0.
2. Simultaneous reads, round-robin, both held for 3 transactions → grants in order 0, 1, 0; each ready pulse goes to the matching requester; busy stays high except in the one IDLE cycle between transactions.
3. fixed_priority=1, both requesters held continuously → r0 served every 4 cycles; r1 never granted until r0 drops, then served once.
4. Write with r1_write_en=1 and r1_read_en=1 together, data 16'h1234 to addr 16'h0002 → only sub_write_en asserted with sub_data_out=16'h1234; r1_data_in unchanged.
5. Buffered downstream model (ready 3 cycles after read issue) → arbiter holds WAIT for 3 cycles; no second strobe is issued.
6. reset=0 asserted asynchronously during WAIT → all strobes and readies drop immediately without a clock edge; after release the first tie goes to r0.
